// File: rtl/dar_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dar_arbiter
// Two-port round-robin arbiter sharing a 4x8 register array between A and B,
// with MAX_BURST-bounded ownership and registered grant/ack/read-data returns.
// Rev    : 1.0
// ============================================================================
module dar_arbiter #(
  parameter int unsigned DW        = 8,
  parameter int unsigned AW        = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          rf_w_en,
  output logic          rf_r_en,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_data_in,
  input  logic [DW-1:0] rf_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  localparam logic [3:0] c_MAX_BURST = 4'(MAX_BURST);

  state_e        state_q, state_d;
  logic [3:0]    burst_cnt_q, burst_cnt_d;
  logic          last_owner_q, last_owner_d;  // 1 = B owned last
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic          w_own_a, w_own_b, w_own_req, w_oth_req, w_access, w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [3:0]    w_cnt_inc;

  always_comb begin
    w_own_a   = (state_q == OWN_A);
    w_own_b   = (state_q == OWN_B);
    w_own_req = (w_own_a & a_req) | (w_own_b & b_req);
    w_oth_req = (w_own_a & b_req) | (w_own_b & a_req);
    w_access  = w_own_req;
    w_we      = w_own_a ? a_we    : b_we;
    w_addr    = w_own_a ? a_addr  : b_addr;
    w_wdata   = w_own_a ? a_wdata : b_wdata;
    w_cnt_inc = burst_cnt_q + 4'd1;
  end

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    a_ack_d      = w_access & w_own_a;
    b_ack_d      = w_access & w_own_b;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;

    if (w_access && !w_we) begin
      if (w_own_a) a_rdata_d = rf_data_out;
      else         b_rdata_d = rf_data_out;
    end

    case (state_q)
      IDLE: begin
        if (a_req && b_req) state_d = last_owner_q ? OWN_A : OWN_B;
        else if (a_req)     state_d = OWN_A;
        else if (b_req)     state_d = OWN_B;
      end
      OWN_A, OWN_B: begin
        if (w_own_req) begin
          burst_cnt_d = w_cnt_inc;
          // Burst limit only forces a handover when the other side is waiting.
          if (w_cnt_inc == c_MAX_BURST) begin
            burst_cnt_d = 4'd0;
            if (w_oth_req) begin
              state_d      = w_own_a ? OWN_B : OWN_A;
              last_owner_d = w_own_b;
            end
          end
        end else begin
          burst_cnt_d  = 4'd0;
          last_owner_d = w_own_b;
          if (w_oth_req) state_d = w_own_a ? OWN_B : OWN_A;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      burst_cnt_q  <= 4'd0;
      last_owner_q <= 1'b1;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  assign a_gnt      = w_own_a;
  assign b_gnt      = w_own_b;
  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign rf_w_en    = w_access & w_we;
  assign rf_r_en    = w_access & ~w_we;
  assign rf_addr    = w_access ? w_addr : '0;
  assign rf_data_in = (w_access && w_we) ? w_wdata : '0;

endmodule
`default_nettype wire
